// File: rtl/mac_row_seq.sv
// One multiprecision multiply-accumulate row R = A*b + C, sequenced limb by limb
// through an external fixed-latency 64-bit MADDL/MADDH multiplier.
module mac_row_seq #(
  parameter int LIMBS = 8,
  parameter int LAT   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [1:0]  ld_sel,
  input  logic [2:0]  ld_idx,
  input  logic [63:0] ld_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [3:0]  rd_idx,
  output logic [63:0] rd_data,
  output logic        mul_req_valid,
  output logic        mul_req_dw,
  output logic [5:0]  mul_req_fn,
  output logic [4:0]  mul_req_tag,
  output logic [63:0] mul_req_in1,
  output logic [63:0] mul_req_in2,
  output logic [63:0] mul_req_in3,
  input  logic [63:0] mul_resp_data,
  input  logic [4:0]  mul_resp_tag
);

  localparam int KW = $clog2(2 * LIMBS);
  localparam int IW = $clog2(LIMBS);
  localparam int RW = $clog2(LIMBS + 1);
  localparam logic [5:0] FN_MADDL = 6'd50;
  localparam logic [5:0] FN_MADDH = 6'd51;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINAL, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [63:0]    a_reg [LIMBS];
  logic [63:0]    c_reg [LIMBS];
  logic [63:0]    b_reg;
  logic [63:0]    r_reg [LIMBS+1];
  logic           carry_reg;
  logic [63:0]    hi_prev_reg;
  logic           err_reg;
  logic [KW-1:0]  k_reg;
  logic [LAT-1:0] pipe_valid_reg;
  logic [4:0]     pipe_tag_reg [LAT];

  logic [IW-1:0]  issue_idx;
  logic           k_last;
  logic [LAT-1:0] pipe_pending;
  logic           drain_empty;
  logic           resp_valid;
  logic [4:0]     resp_tag_exp;
  logic [3:0]     resp_idx;
  logic [64:0]    lo_sum;

  assign issue_idx    = IW'(k_reg >> 1);
  assign k_last       = (k_reg == KW'(2 * LIMBS - 1));
  // Entries not in the exit slot are still outstanding after this cycle.
  assign pipe_pending = LAT'(pipe_valid_reg << 1);
  assign drain_empty  = (pipe_pending == '0);
  assign resp_valid   = pipe_valid_reg[LAT-1];
  assign resp_tag_exp = pipe_tag_reg[LAT-1];
  assign resp_idx     = resp_tag_exp[3:0];
  assign err          = err_reg;
  assign mul_req_dw   = 1'b1;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_ISSUE;
      S_ISSUE: if (k_last) state_next = S_DRAIN;
      S_DRAIN: if (drain_empty) state_next = S_FINAL;
      S_FINAL: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    mul_req_valid = 1'b0;
    mul_req_fn    = '0;
    mul_req_tag   = '0;
    mul_req_in1   = '0;
    mul_req_in2   = '0;
    mul_req_in3   = '0;
    case (state_reg)
      S_ISSUE: begin
        busy          = 1'b1;
        mul_req_valid = 1'b1;
        mul_req_fn    = k_reg[0] ? FN_MADDH : FN_MADDL;
        mul_req_tag   = {k_reg[0], 4'(issue_idx)};
        mul_req_in1   = a_reg[issue_idx];
        mul_req_in2   = b_reg;
        mul_req_in3   = c_reg[issue_idx];
      end
      S_DRAIN, S_FINAL: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default: ;
    endcase
  end

  // Operand registers: writable only while idle.
  always_ff @(posedge clock) begin
    if (state_reg == S_IDLE && ld_valid) begin
      case (ld_sel)
        2'd0: a_reg[ld_idx] <= ld_data;
        2'd1: c_reg[ld_idx] <= ld_data;
        2'd2: b_reg <= ld_data;
        default: ;
      endcase
    end
  end

  // Expected-response pipeline: slot 0 is entry, slot LAT-1 is exit.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid_reg <= '0;
      for (int j = 0; j < LAT; j++) pipe_tag_reg[j] <= '0;
    end else begin
      pipe_valid_reg  <= LAT'({pipe_valid_reg, mul_req_valid});
      pipe_tag_reg[0] <= mul_req_tag;
      for (int j = 1; j < LAT; j++) pipe_tag_reg[j] <= pipe_tag_reg[j-1];
    end
  end

  // Limb 0 starts the chain with no incoming high word or carry.
  always_comb begin
    lo_sum = {1'b0, mul_resp_data};
    if (resp_idx != 4'd0)
      lo_sum = {1'b0, mul_resp_data} + {1'b0, hi_prev_reg} + {64'd0, carry_reg};
  end

  // Row datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j <= LIMBS; j++) r_reg[j] <= '0;
      carry_reg   <= 1'b0;
      hi_prev_reg <= '0;
      err_reg     <= 1'b0;
      k_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j <= LIMBS; j++) r_reg[j] <= '0;
            carry_reg   <= 1'b0;
            hi_prev_reg <= '0;
            err_reg     <= 1'b0;
            k_reg       <= '0;
          end
        end
        S_ISSUE: k_reg <= k_reg + 1'b1;
        S_FINAL: r_reg[LIMBS] <= hi_prev_reg + {63'd0, carry_reg};
        default: ;
      endcase
      if (resp_valid) begin
        if (mul_resp_tag != resp_tag_exp) err_reg <= 1'b1;
        if (!resp_tag_exp[4]) begin
          r_reg[RW'(resp_idx)] <= lo_sum[63:0];
          carry_reg            <= lo_sum[64];
        end else begin
          hi_prev_reg <= mul_resp_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) <= LIMBS) rd_data = r_reg[RW'(rd_idx)];
  end

endmodule

// File: tb/tb_mac_row_seq.sv
// Directed row sequence with random operands; the bench plays the multiplier and
// checks R against a wide-integer evaluation of A*b + C.
module tb_mac_row_seq;
  localparam int LIMBS = 8;
  localparam int LAT   = 2;
  localparam int DONE_CYC = 2 * LIMBS + LAT + 2;

  logic        clock = 1'b0;
  logic        reset, start, ld_valid;
  logic [1:0]  ld_sel;
  logic [2:0]  ld_idx;
  logic [63:0] ld_data;
  logic        busy, done, err;
  logic [3:0]  rd_idx;
  logic [63:0] rd_data;
  logic        mul_req_valid, mul_req_dw;
  logic [5:0]  mul_req_fn;
  logic [4:0]  mul_req_tag;
  logic [63:0] mul_req_in1, mul_req_in2, mul_req_in3;
  logic [63:0] mul_resp_data;
  logic [4:0]  mul_resp_tag;

  mac_row_seq #(.LIMBS(LIMBS), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .ld_valid(ld_valid),
    .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
    .busy(busy), .done(done), .err(err), .rd_idx(rd_idx), .rd_data(rd_data),
    .mul_req_valid(mul_req_valid), .mul_req_dw(mul_req_dw), .mul_req_fn(mul_req_fn),
    .mul_req_tag(mul_req_tag), .mul_req_in1(mul_req_in1), .mul_req_in2(mul_req_in2),
    .mul_req_in3(mul_req_in3), .mul_resp_data(mul_resp_data), .mul_resp_tag(mul_resp_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic [4:0]  tag;
  } resp_t;

  resp_t       rq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          corrupt_at = -1;
  logic [63:0] opa [LIMBS];
  logic [63:0] opc [LIMBS];
  logic [63:0] opb;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance one clock; act as the multiplier for the new cycle.
  task automatic tick();
    logic [127:0] prod;
    resp_t        d;
    @(posedge clock);
    #1;
    cyc++;
    if (mul_req_valid) begin
      prod   = 128'(mul_req_in1) * 128'(mul_req_in2) + 128'(mul_req_in3);
      d.due  = cyc + LAT;
      d.data = (mul_req_fn == 6'd51) ? prod[127:64] : prod[63:0];
      d.tag  = mul_req_tag;
      rq.push_back(d);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      d = rq.pop_front();
      mul_resp_data = d.data;
      mul_resp_tag  = (cyc == corrupt_at) ? 5'h05 : d.tag;
    end else begin
      mul_resp_data = '0;
      mul_resp_tag  = '0;
    end
  endtask

  task automatic ld(input logic [1:0] sel, input logic [2:0] idx, input logic [63:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_idx = idx; ld_data = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_ops();
    for (int i = 0; i < LIMBS; i++) begin
      ld(2'd0, 3'(i), opa[i]);
      ld(2'd1, 3'(i), opc[i]);
    end
    ld(2'd2, 3'd0, opb);
    ld(2'd3, 3'd0, {$urandom, $urandom});
  endtask

  task automatic rand_ops();
    for (int i = 0; i < LIMBS; i++) begin
      opa[i] = {$urandom, $urandom};
      opc[i] = {$urandom, $urandom};
    end
    opb = {$urandom, $urandom};
  endtask

  task automatic fill_ops(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    for (int i = 0; i < LIMBS; i++) begin
      opa[i] = a;
      opc[i] = c;
    end
    opb = b;
  endtask

  task automatic run_row(input string name, input int corrupt, input int rst_at, input int poke_at);
    logic [575:0] wa, wc, wr;
    logic [4:0]   etag;
    logic         aborted, e_busy, e_done, e_valid, e_err;
    int           k;
    for (int i = 0; i < LIMBS; i++) begin
      wa[64*i +: 64] = opa[i];
      wc[64*i +: 64] = opc[i];
    end
    wa[575:512] = '0;
    wc[575:512] = '0;
    wr = wa * 576'(opb) + wc;
    if (rst_at >= 0) wr = '0;
    corrupt_at = corrupt;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= DONE_CYC + 3) begin
      aborted = (rst_at >= 0) && (cyc > rst_at);
      e_busy  = !aborted && cyc >= 1 && cyc <= DONE_CYC - 1;
      e_done  = !aborted && cyc == DONE_CYC;
      e_valid = !aborted && cyc >= 1 && cyc <= 2 * LIMBS;
      e_err   = !aborted && corrupt >= 0 && cyc > corrupt;
      chk($sformatf("%s busy c%0d", name, cyc), 64'(busy), 64'(e_busy));
      chk($sformatf("%s done c%0d", name, cyc), 64'(done), 64'(e_done));
      chk($sformatf("%s err c%0d", name, cyc), 64'(err), 64'(e_err));
      chk($sformatf("%s req_valid c%0d", name, cyc), 64'(mul_req_valid), 64'(e_valid));
      if (e_valid) begin
        k    = cyc - 1;
        etag = 5'((k % 2) * 16 + k / 2);
        chk($sformatf("%s fn c%0d", name, cyc), 64'(mul_req_fn), (k % 2 == 1) ? 64'd51 : 64'd50);
        chk($sformatf("%s tag c%0d", name, cyc), 64'(mul_req_tag), 64'(etag));
        chk($sformatf("%s in1 c%0d", name, cyc), mul_req_in1, opa[k/2]);
        chk($sformatf("%s in2 c%0d", name, cyc), mul_req_in2, opb);
        chk($sformatf("%s in3 c%0d", name, cyc), mul_req_in3, opc[k/2]);
      end else begin
        chk($sformatf("%s idle_req c%0d", name, cyc),
            mul_req_in1 | mul_req_in2 | mul_req_in3 | 64'(mul_req_fn) | 64'(mul_req_tag), 64'd0);
      end
      if (cyc == poke_at) begin
        start = 1'b1; ld_valid = 1'b1; ld_sel = 2'd0; ld_idx = 3'd0; ld_data = 64'd7;
      end
      if (cyc == rst_at) reset = 1'b1;
      tick();
      start = 1'b0;
      ld_valid = 1'b0;
      if (reset) begin
        reset = 1'b0;
        rq.delete();
      end
    end
    for (int j = 0; j <= LIMBS; j++) begin
      rd_idx = 4'(j);
      #1;
      chk($sformatf("%s R[%0d]", name, j), rd_data, wr[64*j +: 64]);
    end
    rd_idx = 4'($urandom_range(LIMBS + 1, 15));
    #1;
    chk($sformatf("%s rd_oob %0d", name, rd_idx), rd_data, 64'd0);
    corrupt_at = -1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_sel = '0; ld_idx = '0; ld_data = '0;
    rd_idx = '0; mul_resp_data = '0; mul_resp_tag = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst req_valid", 64'(mul_req_valid), 64'd0);
    chk("rst req_fields", mul_req_in1 | mul_req_in2 | mul_req_in3 | 64'(mul_req_fn) | 64'(mul_req_tag), 64'd0);
    for (int j = 0; j <= LIMBS; j++) begin
      rd_idx = 4'(j);
      #1;
      chk($sformatf("rst R[%0d]", j), rd_data, 64'd0);
    end

    fill_ops(64'd0, 64'd0, 64'd0);
    load_ops();
    run_row("zero", -1, -1, -1);

    fill_ops(64'd1, 64'd1, 64'd0);
    load_ops();
    run_row("unit", -1, -1, -1);

    fill_ops('1, '1, '1);
    load_ops();
    run_row("carry", -1, -1, -1);

    rand_ops();
    load_ops();
    run_row("tagerr", 5, -1, -1);
    run_row("tagclr", -1, -1, -1);

    rand_ops();
    load_ops();
    run_row("midrst", -1, 10, -1);
    rand_ops();
    load_ops();
    run_row("postrst", -1, -1, -1);

    rand_ops();
    load_ops();
    run_row("poke", -1, -1, 5);
    run_row("repoke", -1, -1, -1);

    for (int t = 0; t < 3; t++) begin
      rand_ops();
      load_ops();
      run_row($sformatf("rand%0d", t), -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
